dif_rr_merge: RTL and testbench

//  Parametrised N-channel valid/ready data merger; successor to the single-channel sim_Dif link.

---
 rtl/dif_rr_merge_if.sv | 43 ++++
 rtl/dif_rr_merge.sv | 157 +++++++++++++++
 tb/tb_dif_rr_merge.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dif_rr_merge_if.sv
// -----------------------------------------------------------------------------
// dif_rr_merge_if
//   Bundle of the N-channel producer side and the single merged consumer side
//   of dif_rr_merge.
//   master : the environment (producers drive i_*, consumer drives o_ready)
//   slave  : the merger itself
// Signals
//   i_data  [NCH*DWd]  channel c occupies bits [c*DWd +: DWd]
//   i_valid [NCH]      per-channel valid
//   i_ready [NCH]      per-channel ready (that channel's FIFO is not full)
//   o_data  [DWd]      merged data word
//   o_ch    [CWd]      source channel of o_data
//   o_valid            merged output valid
//   o_ready            consumer ready
//   o_cnt   [NCH*KWd]  per-channel FIFO occupancy (debug)
// -----------------------------------------------------------------------------
interface dif_rr_merge_if #(
  parameter int DWd   = 16,
  parameter int NCH   = 4,
  parameter int DEPTH = 4
);
  localparam int CWd = $clog2(NCH);
  localparam int KWd = $clog2(DEPTH) + 1;

  logic [NCH*DWd-1:0] i_data;
  logic [NCH-1:0]     i_valid;
  logic [NCH-1:0]     i_ready;
  logic [DWd-1:0]     o_data;
  logic [CWd-1:0]     o_ch;
  logic               o_valid;
  logic               o_ready;
  logic [NCH*KWd-1:0] o_cnt;

  modport master (
    output i_data, i_valid, o_ready,
    input  i_ready, o_data, o_ch, o_valid, o_cnt
  );

  modport slave (
    input  i_data, i_valid, o_ready,
    output i_ready, o_data, o_ch, o_valid, o_cnt
  );
endinterface

// File: rtl/dif_rr_merge.sv
// -----------------------------------------------------------------------------
// dif_rr_merge
//   N-channel valid/ready merger. Every input channel has its own FIFO; an
//   arbiter (round robin or fixed priority) drains the FIFOs into a single
//   registered output stage which tags each word with its source channel.
// Parameters
//   DWd    data width per word
//   NCH    number of input channels (>= 2)
//   DEPTH  per-channel FIFO depth in words (power of 2, >= 2)
//   MODE   0 = round robin, 1 = fixed priority (lowest index wins)
// Ports
//   clk    clock, all state on the rising edge
//   rst    synchronous reset, active high
//   bus    dif_rr_merge_if.slave : i_data/i_valid/i_ready per channel,
//          o_data/o_ch/o_valid/o_ready merged output, o_cnt debug occupancy
// -----------------------------------------------------------------------------
module dif_rr_merge #(
  parameter int DWd   = 16,
  parameter int NCH   = 4,
  parameter int DEPTH = 4,
  parameter int MODE  = 0
) (
  input  logic           clk,
  input  logic           rst,
  dif_rr_merge_if.slave  bus
);

  localparam int CWd = $clog2(NCH);
  localparam int AWd = $clog2(DEPTH);
  localparam int KWd = AWd + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("dif_rr_merge: DEPTH must be a power of 2 and >= 2");
  end
  if (NCH < 2) begin : g_nch_chk
    $error("dif_rr_merge: NCH must be >= 2");
  end

  // Per-channel FIFO state
  logic [DWd-1:0] mem    [NCH][DEPTH];
  logic [AWd-1:0] wr_ptr [NCH];
  logic [AWd-1:0] rd_ptr [NCH];
  logic [KWd-1:0] cnt    [NCH];

  logic [NCH-1:0] ready;
  logic [NCH-1:0] push;
  logic [NCH-1:0] pop;
  logic [NCH-1:0] nonempty;

  // Arbiter / output stage
  logic [CWd-1:0] last;
  logic [CWd-1:0] grant;
  logic           grant_vld;
  logic           load_en;
  logic [DWd-1:0] head;

  logic           o_valid_q;
  logic [DWd-1:0] o_data_q;
  logic [CWd-1:0] o_ch_q;

  // The output register may take a new word when empty or being consumed.
  assign load_en = !o_valid_q || bus.o_ready;

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    // Ready comes from the registered count only, so a full channel stays
    // not-ready in the cycle it is popped and reopens one cycle later.
    assign ready[c]    = (cnt[c] != KWd'(DEPTH));
    assign nonempty[c] = (cnt[c] != '0);
    assign push[c]     = bus.i_valid[c] && ready[c];
    assign pop[c]      = load_en && grant_vld && (grant == CWd'(c));

    assign bus.i_ready[c]              = ready[c];
    assign bus.o_cnt[c*KWd +: KWd]     = cnt[c];
  end

  // Arbiter: looks at FIFO occupancy only, never at i_valid.
  // Both searches run from the lowest-priority candidate to the highest so
  // the last hit, i.e. the highest-priority non-empty channel, is kept.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves a value unassigned and no latch is inferred.
    grant     = '0;
    grant_vld = 1'b0;
    if (MODE == 1) begin
      for (int i = NCH - 1; i >= 0; i--) begin
        if (nonempty[i]) begin
          grant     = CWd'(i);
          grant_vld = 1'b1;
        end
      end
    end else begin
      // Offsets NCH down to 1 from the last grant: offset 1 (last+1) is best.
      for (int i = NCH; i >= 1; i--) begin
        if (nonempty[(int'(last) + i) % NCH]) begin
          grant     = CWd'((int'(last) + i) % NCH);
          grant_vld = 1'b1;
        end
      end
    end
  end

  assign head = mem[grant][rd_ptr[grant]];

  // FIFO storage
  // NOTE: the data array has no reset; validity is tracked by the reset
  // pointers and counts, and leaving it out keeps it mappable to RAM.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) begin
        mem[c][wr_ptr[c]] <= bus.i_data[c*DWd +: DWd];
      end
    end
  end

  // FIFO control and output register
  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        wr_ptr[c] <= '0;
        rd_ptr[c] <= '0;
        cnt[c]    <= '0;
      end
      last      <= CWd'(NCH - 1);
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_ch_q    <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
        if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
        case ({push[c], pop[c]})
          2'b10:   cnt[c] <= cnt[c] + 1'b1;
          2'b01:   cnt[c] <= cnt[c] - 1'b1;
          default: cnt[c] <= cnt[c];
        endcase
      end

      if (load_en) begin
        if (grant_vld) begin
          o_valid_q <= 1'b1;
          o_data_q  <= head;
          o_ch_q    <= grant;
          last      <= grant;
        end else begin
          o_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_ch    = o_ch_q;

endmodule

// File: tb/tb_dif_rr_merge.sv
// -----------------------------------------------------------------------------
// tb_dif_rr_merge
//   Scoreboard bench for dif_rr_merge. dut0 is round robin, dut1 is fixed
//   priority. Stimulus pushes the hand-derived output order into a queue per
//   DUT; a monitor pops and compares on every output handshake and checks
//   that a stalled output word is held stable.
// -----------------------------------------------------------------------------
module tb_dif_rr_merge;

  localparam int DWd   = 16;
  localparam int NCH   = 4;
  localparam int DEPTH = 4;
  localparam int KWd   = 3;

  typedef struct packed {
    logic [DWd-1:0] data;
    logic [1:0]     ch;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dif_rr_merge_if #(.DWd(DWd), .NCH(NCH), .DEPTH(DEPTH)) bus0 ();
  dif_rr_merge_if #(.DWd(DWd), .NCH(NCH), .DEPTH(DEPTH)) bus1 ();

  dif_rr_merge #(.DWd(DWd), .NCH(NCH), .DEPTH(DEPTH), .MODE(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  dif_rr_merge #(.DWd(DWd), .NCH(NCH), .DEPTH(DEPTH), .MODE(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q0[$];
  exp_t q1[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [DWd-1:0] d, input int c);
    exp_t e;
    e.data = d;
    e.ch   = 2'(c);
    return e;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitors: sample at the falling edge, half a cycle away from the DUT edge.
  // ---------------------------------------------------------------------------
  logic           stall0 = 1'b0;
  logic [DWd-1:0] held_data0;
  logic [1:0]     held_ch0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall0 = 1'b0;
    end else begin
      if (stall0) begin
        check("stall_valid_held", 32'(bus0.o_valid), 32'd1);
        check("stall_data_held",  32'(bus0.o_data),  32'(held_data0));
        check("stall_ch_held",    32'(bus0.o_ch),    32'(held_ch0));
      end
      if (bus0.o_valid && bus0.o_ready) begin
        if (q0.size() == 0) begin
          check("dut0_unexpected_word", 32'(q0.size()), 32'd1);
        end else begin
          e = q0.pop_front();
          check("dut0_data", 32'(bus0.o_data), 32'(e.data));
          check("dut0_ch",   32'(bus0.o_ch),   32'(e.ch));
        end
      end
      stall0     = bus0.o_valid && !bus0.o_ready;
      held_data0 = bus0.o_data;
      held_ch0   = bus0.o_ch;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus1.o_valid && bus1.o_ready) begin
      if (q1.size() == 0) begin
        check("dut1_unexpected_word", 32'(q1.size()), 32'd1);
      end else begin
        e = q1.pop_front();
        check("dut1_data", 32'(bus1.o_data), 32'(e.data));
        check("dut1_ch",   32'(bus1.o_ch),   32'(e.ch));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All tasks start and end at posedge + #1.
  // ---------------------------------------------------------------------------
  task automatic do_reset();
    rst          = 1'b1;
    bus0.i_valid = '0;
    bus1.i_valid = '0;
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One cycle of parallel pushes on dut0; every channel in m must be ready.
  task automatic tick_push0(input logic [3:0] m, input logic [DWd-1:0] d0,
                            input logic [DWd-1:0] d1, input logic [DWd-1:0] d2,
                            input logic [DWd-1:0] d3);
    bus0.i_data  = {d3, d2, d1, d0};
    bus0.i_valid = m;
    @(negedge clk);
    check("push_ready", 32'(bus0.i_ready & m), 32'(m));
    @(posedge clk);
    #1 bus0.i_valid = '0;
  endtask

  task automatic drain0(input int budget);
    int n = 0;
    while (q0.size() != 0 && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    check("dut0_drained", 32'(q0.size()), 32'd0);
  endtask

  task automatic drain1(input int budget);
    int n = 0;
    while (q1.size() != 0 && n < budget) begin
      @(posedge clk);
      #1 n++;
    end
    check("dut1_drained", 32'(q1.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus0.i_data  = '0;
    bus0.i_valid = '0;
    bus0.o_ready = 1'b0;
    bus1.i_data  = '0;
    bus1.i_valid = '0;
    bus1.o_ready = 1'b1;

    // ---- Reset state ----
    do_reset();
    @(negedge clk);
    check("rst_o_valid", 32'(bus0.o_valid), 32'd0);
    check("rst_o_data",  32'(bus0.o_data),  32'd0);
    check("rst_o_ch",    32'(bus0.o_ch),    32'd0);
    check("rst_i_ready", 32'(bus0.i_ready), 32'hF);
    check("rst_o_cnt",   32'(bus0.o_cnt),   32'd0);
    @(posedge clk);
    #1;

    // ---- 1: single word on ch1, two-stage latency ----
    bus0.o_ready = 1'b1;
    q0.push_back(mk(16'h0101, 1));
    bus0.i_data  = {16'h0, 16'h0, 16'h0101, 16'h0};
    bus0.i_valid = 4'b0010;
    @(negedge clk);
    check("t1_ready", 32'(bus0.i_ready[1]), 32'd1);
    @(posedge clk);                       // word written into FIFO here
    #1 bus0.i_valid = '0;
    @(negedge clk);
    check("t1_not_yet_valid", 32'(bus0.o_valid), 32'd0);
    check("t1_cnt_ch1",       32'(bus0.o_cnt[KWd +: KWd]), 32'd1);
    @(posedge clk);                       // output register loads here
    @(negedge clk);
    check("t1_valid", 32'(bus0.o_valid), 32'd1);
    @(posedge clk);
    #1 drain0(10);

    // ---- 2: all channels with 3 words, round-robin order ----
    do_reset();
    bus0.o_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick_push0(4'hF, 16'(16'h000 + k), 16'(16'h100 + k),
                       16'(16'h200 + k), 16'(16'h300 + k));
    end
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < NCH; c++) q0.push_back(mk(16'(c * 256 + k), c));
    end
    bus0.o_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("t2_back_to_back", 32'(bus0.o_valid), 32'd1);
      @(posedge clk);
      #1;
    end
    drain0(10);

    // ---- 3: ch2 overflow while output is stalled ----
    do_reset();
    bus0.o_ready = 1'b0;
    q0.push_back(mk(16'h0AAA, 0));
    tick_push0(4'b0001, 16'h0AAA, 16'h0, 16'h0, 16'h0);
    @(posedge clk);                       // ch0 word moves into the output stage
    #1;
    for (int k = 0; k < 5; k++) q0.push_back(mk(16'(16'h2200 + k), 2));
    for (int k = 0; k < 4; k++) tick_push0(4'b0100, 16'h0, 16'h0, 16'(16'h2200 + k), 16'h0);
    bus0.i_data  = {16'h0, 16'h2204, 16'h0, 16'h0};
    bus0.i_valid = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("t3_full_not_ready", 32'(bus0.i_ready[2]), 32'd0);
      check("t3_cnt_full",       32'(bus0.o_cnt[2*KWd +: KWd]), 32'd4);
      @(posedge clk);
      #1;
    end
    bus0.o_ready = 1'b1;
    @(negedge clk);                       // ch2 is popped this cycle but still full
    check("t3_ready_stays_low", 32'(bus0.i_ready[2]), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("t3_ready_reopens", 32'(bus0.i_ready[2]), 32'd1);
    @(posedge clk);                       // fifth word accepted
    #1 bus0.i_valid = '0;
    drain0(20);

    // ---- 4: random backpressure on ch1/ch3 traffic ----
    do_reset();
    bus0.o_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick_push0(4'b1010, 16'h0, 16'(16'h1100 + k), 16'h0, 16'(16'h3300 + k));
    end
    // ch1 w0 was granted first (last = 3 after reset), then strict alternation.
    q0.push_back(mk(16'h1100, 1));
    for (int k = 0; k < 3; k++) begin
      q0.push_back(mk(16'(16'h3300 + k), 3));
      q0.push_back(mk(16'(16'h1101 + k), 1));
    end
    q0.push_back(mk(16'h3303, 3));
    for (int k = 0; k < 50; k++) begin
      bus0.o_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    bus0.o_ready = 1'b1;
    drain0(20);

    // ---- 5: fixed priority, ch3 starved while ch0 is fed ----
    bus1.o_ready = 1'b1;
    for (int k = 0; k < 6; k++) q1.push_back(mk(16'(16'h0A00 + k), 0));
    for (int k = 0; k < 3; k++) q1.push_back(mk(16'(16'h3B00 + k), 3));
    for (int k = 0; k < 6; k++) begin
      bus1.i_data  = {16'(16'h3B00 + k), 16'h0, 16'h0, 16'(16'h0A00 + k)};
      bus1.i_valid = (k < 3) ? 4'b1001 : 4'b0001;
      @(negedge clk);
      check("t5_push_ready", 32'(bus1.i_ready & bus1.i_valid), 32'(bus1.i_valid));
      @(posedge clk);
      #1;
    end
    bus1.i_valid = '0;
    drain1(20);

    // ---- 6: reset with buffered words and a stalled output ----
    do_reset();
    bus0.o_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick_push0(4'b0011, 16'(16'h6000 + k), 16'(16'h6100 + k), 16'h0, 16'h0);
    tick_push0(4'b0001, 16'h6003, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    check("t6_pre_valid", 32'(bus0.o_valid), 32'd1);
    check("t6_pre_cnt",   32'(bus0.o_cnt),   32'h01B);   // ch0 = 3, ch1 = 3
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("t6_valid_dropped", 32'(bus0.o_valid), 32'd0);
    check("t6_i_ready",       32'(bus0.i_ready), 32'hF);
    check("t6_cnt_zero",      32'(bus0.o_cnt),   32'd0);
    check("t6_data_zero",     32'(bus0.o_data),  32'd0);
    @(posedge clk);
    #1;
    bus0.o_ready = 1'b1;
    q0.push_back(mk(16'h7000, 0));
    q0.push_back(mk(16'h7003, 3));
    tick_push0(4'b1001, 16'h7000, 16'h0, 16'h0, 16'h7003);
    drain0(10);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
